spi_eeprom_ctrl: RTL and testbench
==================================

# spi_eeprom_ctrl

Transaction controller for the RM25C256DS SPI EEPROM. It accepts single-byte read and write requests from the fabric, sequences the device command frames, and drives `csb`, `sck` and `sdo`. A write is issued as WREN, then WRITE, then RDSR polling until the write completes. The block sits between user logic and the EEPROM pins and replaces free-running serial data generation with a request/response handshake.

## Interface
- `CLK_SCK_SCAL`, 40: clk cycles per SCK bit period; even, ≥4.
- `OP_CYC`, 8: bits per command/address/data field.
- `POLL_MAX`, 1024: maximum RDSR polls before a write is aborted with an error.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller idle and able to accept a request.
- `req_wr`  in  1  1 = write byte, 0 = read byte.
- `req_addr`  in  16  byte address; bit 15 is ignored, since the device is 32 KB.
- `req_wdata`  in  8  write data.
- `rsp_valid`  out  1  one-cycle completion pulse.
- `rsp_rdata`  out  8  read data; holds its value until the next read completes.
- `rsp_err`  out  1  valid with `rsp_valid`; poll timeout.
- `csb`  out  1  chip select, active low.
- `sck`  out  1  SPI clock, mode 0.
- `sdo`  out  1  controller to EEPROM SI.
- `sdi`  in  1  EEPROM SO to controller; already synchronised.

## Operation
- Opcodes: WREN 0x06, WRITE 0x02, READ 0x03, RDSR 0x05. All bits are sent MSB first.
- Address is sent as two bytes: {1'b0, req_addr[14:8]} then req_addr[7:0].
- Request is accepted on `req_valid && req_ready`. Inputs are registered at acceptance.
- FSM states: IDLE, WREN, GAP_W, WRITE, GAP_P, POLL, READ, DONE.
- IDLE to READ (`req_wr`=0) or IDLE to WREN (`req_wr`=1).
- READ frame: 32 bits (opcode, addr hi, addr lo, 8 receive bits). `sdo` is 0 during the receive byte. Then DONE.
- WREN frame: 8 bits. Then GAP_W, then WRITE frame of 32 bits (opcode, addr hi, addr lo, wdata). Then GAP_P, then POLL.
- POLL frame: 16 bits (RDSR, then 8 receive bits).
  - Status bit 0 (WIP) = 0: go to DONE.
  - WIP = 1: go to GAP_P and poll again.
  - The POLL_MAX-th poll still returns WIP = 1: go to DONE with `rsp_err`=1.
- DONE lasts one cycle: `rsp_valid`=1, then IDLE.
- `req_ready` = 1 only in IDLE.
- `rsp_rdata` updates only on a successful read.

## Timing
- Reset values: `csb`=1, `sck`=0, `sdo`=0, `req_ready`=1 (from the first cycle after reset), `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0. State = IDLE and all counters = 0.
- `csb` falls on the clock edge after acceptance.
- A frame of N bits holds `csb` low for exactly N·CLK_SCK_SCAL cycles.
- Bit period: `cnt` runs 0 to CLK_SCK_SCAL-1.
  - `sck`=0 for `cnt` < CLK_SCK_SCAL/2, and 1 otherwise.
  - `sdo` changes only when `cnt`=0.
  - `sdi` is sampled when `cnt`=CLK_SCK_SCAL/2 (SCK rising edge).
- Gap states hold `csb` high for exactly CLK_SCK_SCAL cycles.
- `csb` rises on the edge after the last bit period ends.
- Read latency, acceptance to `rsp_valid`: 1 + 32·CLK_SCK_SCAL cycles.
- Write latency: 1 + 8S + S + 32S + k·(S + 16S) cycles, where S = CLK_SCK_SCAL and k = number of polls.
- Bit counter width: $clog2(4·OP_CYC+1). Poll counter width: $clog2(POLL_MAX+1). No wrap occurs within a frame.
- `req_valid` asserted during DONE is not accepted until the following IDLE cycle, so back-to-back requests have at least one idle cycle between them.
- Reset mid-frame: on the next edge, `csb` goes to 1, `sck` and `sdo` go to 0, and the FSM goes to IDLE. No `rsp_valid` is issued, and the aborted transaction is discarded.

## Structure
- Package `spi_eeprom_pkg` holds:
  - opcode localparams;
  - the `state_t` enum;
  - frame-length constants (8, 16, 32).
- Sub-module `spi_frame_shifter`:
  - inputs: `start`, `nbits`, 32-bit `tx_word` (left aligned), `sdi`;
  - outputs: `csb`, `sck`, `sdo`, `rx_byte` (last 8 sampled bits), `done` (1-cycle pulse);
  - contains the SCK divider and bit counter.
- The top-level FSM and poll counter live in `spi_eeprom_ctrl`.

## Test plan
All scenarios use CLK_SCK_SCAL=4 and POLL_MAX=4 unless noted, with a behavioural EEPROM model on the SPI pins.

1. Reset, then idle: `csb`=1, `sck`=0, `sdo`=0, `req_ready`=1, and no `rsp_valid` over 100 cycles.
2. Read 0x1234, model returns 0xA5:
   - `csb` is low for exactly 128 cycles;
   - `sdo` bits are 0x03, 0x12, 0x34;
   - `rsp_valid` arrives at cycle 129 after acceptance, with `rsp_rdata`=0xA5 and `rsp_err`=0.
3. Write 0x5A to 0x7FFF, model WIP busy for 2 polls:
   - `sdo` carries 0x06, then 0x02 7F FF 5A, then 3 RDSR frames;
   - each gap is 4 cycles;
   - `rsp_valid` arrives at cycle 1+32+4+128+3·68 = 369, with `rsp_err`=0.
4. Write with WIP stuck at 1: exactly 4 polls are issued, then `rsp_valid`=1 with `rsp_err`=1, and `rsp_rdata` is unchanged.
5. Reset asserted at cycle 60 of a read: `csb`=1 on the next edge, no `rsp_valid`, and a subsequent read of 0x0001 completes correctly.
6. `req_valid` held high for two reads: second acceptance occurs exactly 1 cycle after the first `rsp_valid`, and `req_ready`=0 throughout the first transaction.

Source files
------------

// File: rtl/spi_eeprom_pkg.sv
// Shared opcodes, frame lengths and FSM state type for the SPI EEPROM controller.
package spi_eeprom_pkg;

   localparam logic [7:0] OP_WREN  = 8'h06;
   localparam logic [7:0] OP_WRITE = 8'h02;
   localparam logic [7:0] OP_READ  = 8'h03;
   localparam logic [7:0] OP_RDSR  = 8'h05;

   localparam int unsigned FRAME_CMD  = 8;
   localparam int unsigned FRAME_POLL = 16;
   localparam int unsigned FRAME_XFER = 32;

   typedef enum logic [2:0] {
      StIdle, StWren, StGapW, StWrite, StGapP, StPoll, StRead, StDone
   } state_t;

endpackage

// File: rtl/spi_frame_shifter.sv
// Mode-0 SPI frame engine: SCK divider, bit counter, MSB-first shift out and byte capture.
module spi_frame_shifter #(
   parameter int unsigned CLK_SCK_SCAL = 40,
   parameter int unsigned OP_CYC       = 8,
   localparam int unsigned BitW        = $clog2(4 * OP_CYC + 1)
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            start_i,
   input  logic [BitW-1:0] nbits_i,
   input  logic [31:0]     tx_word_i,
   input  logic            sdi_i,
   output logic            csb_o,
   output logic            sck_o,
   output logic            sdo_o,
   output logic [7:0]      rx_byte_o,
   output logic            done_o
);

   localparam int unsigned CntW = $clog2(CLK_SCK_SCAL);
   localparam logic [CntW-1:0] CntLast = CntW'(CLK_SCK_SCAL - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(CLK_SCK_SCAL / 2);

   logic            busy_q, busy_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [BitW-1:0] bit_q, bit_d;
   logic [BitW-1:0] nbits_q, nbits_d;
   logic [31:0]     shift_q, shift_d;
   logic [7:0]      rx_q, rx_d;
   logic            bit_last;

   assign bit_last  = (bit_q == nbits_q - BitW'(1));
   assign done_o    = busy_q && (cnt_q == CntLast) && bit_last;
   assign csb_o     = ~busy_q;
   assign sck_o     = busy_q && (cnt_q >= CntHalf);
   assign sdo_o     = busy_q & shift_q[31];
   assign rx_byte_o = rx_q;

   always_comb begin
      busy_d  = busy_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      nbits_d = nbits_q;
      shift_d = shift_q;
      rx_d    = rx_q;
      if (!busy_q) begin
         if (start_i) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            bit_d   = '0;
            nbits_d = nbits_i;
            shift_d = tx_word_i;
         end
      end else begin
         // Sample on the SCK rising edge, shift at the end of the bit period.
         if (cnt_q == CntHalf) begin
            rx_d = {rx_q[6:0], sdi_i};
         end
         if (cnt_q == CntLast) begin
            cnt_d   = '0;
            shift_d = {shift_q[30:0], 1'b0};
            if (bit_last) begin
               busy_d = 1'b0;
               bit_d  = '0;
            end else begin
               bit_d = bit_q + BitW'(1);
            end
         end else begin
            cnt_d = cnt_q + CntW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         bit_q   <= '0;
         nbits_q <= '0;
         shift_q <= '0;
         rx_q    <= '0;
      end else begin
         busy_q  <= busy_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         nbits_q <= nbits_d;
         shift_q <= shift_d;
         rx_q    <= rx_d;
      end
   end

endmodule

// File: rtl/spi_eeprom_ctrl.sv
// Request/response transaction controller for an SPI EEPROM: read, and write with WIP polling.
module spi_eeprom_ctrl
   import spi_eeprom_pkg::*;
#(
   parameter int unsigned CLK_SCK_SCAL = 40,
   parameter int unsigned OP_CYC       = 8,
   parameter int unsigned POLL_MAX     = 1024
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_wr_i,
   input  logic [15:0] req_addr_i,
   input  logic [7:0]  req_wdata_i,
   output logic        rsp_valid_o,
   output logic [7:0]  rsp_rdata_o,
   output logic        rsp_err_o,
   output logic        csb_o,
   output logic        sck_o,
   output logic        sdo_o,
   input  logic        sdi_i
);

   localparam int unsigned BitW  = $clog2(4 * OP_CYC + 1);
   localparam int unsigned PollW = $clog2(POLL_MAX + 1);
   localparam int unsigned GapW  = $clog2(CLK_SCK_SCAL);
   // The frame state spends one cycle launching the shifter, so the gap state runs S-1 cycles.
   localparam logic [GapW-1:0]  GapLast  = GapW'(CLK_SCK_SCAL - 2);
   localparam logic [PollW-1:0] PollLast = PollW'(POLL_MAX - 1);

   state_t           state_q, state_d;
   logic [15:0]      addr_q, addr_d;
   logic [7:0]       wdata_q, wdata_d;
   logic [7:0]       rdata_q, rdata_d;
   logic             err_q, err_d;
   logic [PollW-1:0] poll_q, poll_d;
   logic [GapW-1:0]  gap_q, gap_d;

   logic             sh_start, sh_csb, sh_done;
   logic [BitW-1:0]  sh_nbits;
   logic [31:0]      sh_tx;
   logic [7:0]       sh_rx;
   logic [7:0]       addr_hi;

   assign addr_hi     = addr_q[15:8] & 8'h7F;
   assign req_ready_o = (state_q == StIdle);
   assign rsp_valid_o = (state_q == StDone);
   assign rsp_err_o   = (state_q == StDone) && err_q;
   assign rsp_rdata_o = rdata_q;
   assign csb_o       = sh_csb;

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      err_d    = err_q;
      poll_d   = poll_q;
      gap_d    = '0;
      sh_start = 1'b0;
      sh_nbits = '0;
      sh_tx    = '0;
      unique case (state_q)
         StIdle: begin
            if (req_valid_i) begin
               addr_d  = req_addr_i;
               wdata_d = req_wdata_i;
               err_d   = 1'b0;
               poll_d  = '0;
               state_d = req_wr_i ? StWren : StRead;
            end
         end
         StWren: begin
            sh_nbits = BitW'(FRAME_CMD);
            sh_tx    = {OP_WREN, 24'h0};
            sh_start = sh_csb;
            if (sh_done) state_d = StGapW;
         end
         StGapW: begin
            gap_d = gap_q + GapW'(1);
            if (gap_q == GapLast) begin
               gap_d   = '0;
               state_d = StWrite;
            end
         end
         StWrite: begin
            sh_nbits = BitW'(FRAME_XFER);
            sh_tx    = {OP_WRITE, addr_hi, addr_q[7:0], wdata_q};
            sh_start = sh_csb;
            if (sh_done) state_d = StGapP;
         end
         StGapP: begin
            gap_d = gap_q + GapW'(1);
            if (gap_q == GapLast) begin
               gap_d   = '0;
               state_d = StPoll;
            end
         end
         StPoll: begin
            sh_nbits = BitW'(FRAME_POLL);
            sh_tx    = {OP_RDSR, 24'h0};
            sh_start = sh_csb;
            if (sh_done) begin
               poll_d = poll_q + PollW'(1);
               if (!sh_rx[0]) begin
                  state_d = StDone;
               end else if (poll_q == PollLast) begin
                  err_d   = 1'b1;
                  state_d = StDone;
               end else begin
                  state_d = StGapP;
               end
            end
         end
         StRead: begin
            sh_nbits = BitW'(FRAME_XFER);
            sh_tx    = {OP_READ, addr_hi, addr_q[7:0], 8'h00};
            sh_start = sh_csb;
            if (sh_done) begin
               rdata_d = sh_rx;
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         poll_q  <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         poll_q  <= poll_d;
         gap_q   <= gap_d;
      end
   end

   spi_frame_shifter #(
      .CLK_SCK_SCAL (CLK_SCK_SCAL),
      .OP_CYC       (OP_CYC)
   ) u_shifter (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .start_i   (sh_start),
      .nbits_i   (sh_nbits),
      .tx_word_i (sh_tx),
      .sdi_i     (sdi_i),
      .csb_o     (sh_csb),
      .sck_o     (sck_o),
      .sdo_o     (sdo_o),
      .rx_byte_o (sh_rx),
      .done_o    (sh_done)
   );

endmodule

// File: tb/tb_spi_eeprom_ctrl.sv
// Directed bench for spi_eeprom_ctrl with a cycle-level EEPROM model on the SPI pins.
module tb_spi_eeprom_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_wr = 1'b0;
   logic [15:0] req_addr = '0;
   logic [7:0]  req_wdata = '0;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_err;
   logic        csb, sck, sdo;
   logic        sdi = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   // Model / monitor state, written only by the monitor process.
   int          cyc = 0;
   logic        sck_prev = 1'b0;
   int          low_cnt = 0, hi_cnt = 0, nbit = 0;
   logic [31:0] mosi_sr = '0;
   logic [7:0]  op = '0;
   int          nfr = 0;
   int          fr_len[64];
   int          fr_nbits[64];
   int          fr_gap[64];
   logic [31:0] fr_bits[64];
   int          n_acc = 0, n_rsp = 0;
   int          acc_cyc[64];
   int          rsp_cyc[64];
   logic [7:0]  rsp_data[64];
   logic        rsp_errl[64];
   int          ready_hi = 0;
   logic        in_txn = 1'b0;
   int          rdsr_total = 0;

   // Model controls, written only by the stimulus process.
   logic [7:0]  mem_byte = '0;
   logic        stuck = 1'b0;
   int          wip_until = 0;

   spi_eeprom_ctrl #(
      .CLK_SCK_SCAL (4),
      .OP_CYC       (8),
      .POLL_MAX     (4)
   ) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_wr_i    (req_wr),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
      .csb_o       (csb),
      .sck_o       (sck),
      .sdo_o       (sdo),
      .sdi_i       (sdi)
   );

   always #5 clk = ~clk;

   function automatic logic resp_bit(input logic [7:0] o, input int n, input logic [7:0] mb,
                                     input logic wip);
      if (o == 8'h03 && n >= 24 && n < 32) return mb[3'(31 - n)];
      if (o == 8'h05 && n == 15) return wip;
      return 1'b0;
   endfunction

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      sck_prev <= sck;
      if (reset === 1'b1) begin
         in_txn <= 1'b0;
      end else begin
         if (req_valid === 1'b1 && req_ready === 1'b1) begin
            if (n_acc < 64) acc_cyc[n_acc] <= cyc;
            n_acc  <= n_acc + 1;
            in_txn <= 1'b1;
         end else if (in_txn && req_ready === 1'b1) begin
            ready_hi <= ready_hi + 1;
         end
         if (rsp_valid === 1'b1) begin
            if (n_rsp < 64) begin
               rsp_cyc[n_rsp]  <= cyc;
               rsp_data[n_rsp] <= rsp_rdata;
               rsp_errl[n_rsp] <= rsp_err;
            end
            n_rsp  <= n_rsp + 1;
            in_txn <= 1'b0;
         end
      end
      if (csb === 1'b0) begin
         low_cnt <= low_cnt + 1;
         if (low_cnt == 0) begin
            if (nfr < 64) fr_gap[nfr] <= hi_cnt;
            hi_cnt  <= 0;
            nbit    <= 0;
            mosi_sr <= '0;
            op      <= '0;
         end else if (sck === 1'b1 && sck_prev === 1'b0) begin
            mosi_sr <= {mosi_sr[30:0], sdo};
            nbit    <= nbit + 1;
            if (nbit == 7) op <= {mosi_sr[6:0], sdo};
         end else if (sck === 1'b0 && sck_prev === 1'b1) begin
            sdi <= resp_bit(op, nbit, mem_byte, stuck || (rdsr_total < wip_until));
         end
      end else begin
         hi_cnt <= hi_cnt + 1;
         sdi    <= 1'b0;
         if (low_cnt > 0) begin
            if (nfr < 64) begin
               fr_len[nfr]   <= low_cnt;
               fr_bits[nfr]  <= mosi_sr;
               fr_nbits[nfr] <= nbit;
            end
            nfr     <= nfr + 1;
            low_cnt <= 0;
            if (op == 8'h05 && nbit == 16) rdsr_total <= rdsr_total + 1;
         end
      end
   end

   task automatic do_req(input logic wr, input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = wr;
      req_addr  = a;
      req_wdata = d;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int target, input int budget, input string name);
      int i;
      i = 0;
      while (n_rsp < target && i < budget) begin
         @(negedge clk);
         i++;
      end
      n_checks++;
      if (n_rsp < target) begin
         n_fail++;
         $display("FAIL %s_timeout: rsp count %0d, required %0d", name, n_rsp, target);
      end
   endtask

   task automatic test_reset();
      int bad;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({csb, sck, sdo} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_pins: csb/sck/sdo %b, required 100", {csb, sck, sdo});
      end
      n_checks++;
      if ({req_ready, rsp_valid, rsp_err} !== 3'b100) begin
         n_fail++;
         $display("FAIL reset_hs: ready/valid/err %b, required 100", {req_ready, rsp_valid, rsp_err});
      end
      n_checks++;
      if (rsp_rdata !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_rdata: got %h, required 00", rsp_rdata);
      end
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (csb !== 1'b1 || sck !== 1'b0 || sdo !== 1'b0 || req_ready !== 1'b1 ||
             rsp_valid !== 1'b0) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL idle_100: %0d bad cycles, required 0", bad);
      end
   endtask

   task automatic check_read(input int rb, input int ab, input int fb, input logic [23:0] hdr,
                             input logic [7:0] exp, input string name);
      logic [31:0] bits;
      int lat;
      bits = fr_bits[fb];
      lat  = rsp_cyc[rb] - acc_cyc[ab] - 1;
      n_checks++;
      if (fr_len[fb] != 128 || fr_nbits[fb] != 32) begin
         n_fail++;
         $display("FAIL %s_frame: len %0d bits %0d, required 128 32", name, fr_len[fb], fr_nbits[fb]);
      end
      n_checks++;
      if (bits !== {hdr, 8'h00}) begin
         n_fail++;
         $display("FAIL %s_sdo: got %h, required %h", name, bits, {hdr, 8'h00});
      end
      n_checks++;
      if (lat != 129) begin
         n_fail++;
         $display("FAIL %s_latency: got %0d, required 129", name, lat);
      end
      n_checks++;
      if (rsp_data[rb] !== exp || rsp_errl[rb] !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_rsp: data %h err %b, required %h 0", name, rsp_data[rb], rsp_errl[rb], exp);
      end
   endtask

   task automatic test_read();
      int rb, ab, fb;
      rb = n_rsp; ab = n_acc; fb = nfr;
      mem_byte = 8'hA5;
      do_req(1'b0, 16'h1234, 8'h00);
      wait_rsp(rb + 1, 400, "read");
      check_read(rb, ab, fb, 24'h031234, 8'hA5, "read");
      repeat (5) @(negedge clk);
      n_checks++;
      if (n_rsp != rb + 1 || rsp_rdata !== 8'hA5) begin
         n_fail++;
         $display("FAIL read_pulse: rsp count %0d rdata %h, required %0d a5", n_rsp - rb, rsp_rdata, 1);
      end
   endtask

   task automatic test_write();
      int rb, ab, fb, lat, bad;
      rb = n_rsp; ab = n_acc; fb = nfr;
      stuck = 1'b0;
      wip_until = rdsr_total + 2;
      do_req(1'b1, 16'h7FFF, 8'h5A);
      wait_rsp(rb + 1, 1000, "write");
      n_checks++;
      if (nfr - fb != 5) begin
         n_fail++;
         $display("FAIL write_nframes: got %0d, required 5", nfr - fb);
      end
      n_checks++;
      if (fr_bits[fb] !== 32'h06 || fr_len[fb] != 32) begin
         n_fail++;
         $display("FAIL write_wren: bits %h len %0d, required 00000006 32", fr_bits[fb], fr_len[fb]);
      end
      n_checks++;
      if (fr_bits[fb+1] !== 32'h027FFF5A || fr_len[fb+1] != 128) begin
         n_fail++;
         $display("FAIL write_frame: bits %h len %0d, required 027fff5a 128", fr_bits[fb+1],
                  fr_len[fb+1]);
      end
      bad = 0;
      for (int i = 2; i < 5; i++) begin
         if (fr_bits[fb+i] !== 32'h0500 || fr_len[fb+i] != 64) bad++;
      end
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL write_polls: %0d bad RDSR frames, required 0", bad);
      end
      bad = 0;
      for (int i = 1; i < 5; i++) if (fr_gap[fb+i] != 4) bad++;
      n_checks++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL write_gaps: %0d gaps not 4 cycles, required 0", bad);
      end
      lat = rsp_cyc[rb] - acc_cyc[ab] - 1;
      n_checks++;
      if (lat != 369 || rsp_errl[rb] !== 1'b0) begin
         n_fail++;
         $display("FAIL write_rsp: latency %0d err %b, required 369 0", lat, rsp_errl[rb]);
      end
   endtask

   task automatic test_write_timeout();
      int rb, ab, fb, lat, polls;
      rb = n_rsp; ab = n_acc; fb = nfr;
      stuck = 1'b1;
      do_req(1'b1, 16'hFFFF, 8'hC3);
      wait_rsp(rb + 1, 1000, "timeout");
      stuck = 1'b0;
      polls = 0;
      for (int i = 0; i < nfr - fb && i < 16; i++) if (fr_bits[fb+i] === 32'h0500) polls++;
      n_checks++;
      if (polls != 4 || nfr - fb != 6) begin
         n_fail++;
         $display("FAIL timeout_polls: polls %0d frames %0d, required 4 6", polls, nfr - fb);
      end
      n_checks++;
      if (fr_bits[fb+1] !== 32'h027FFFC3) begin
         n_fail++;
         $display("FAIL timeout_addr15: got %h, required 027fffc3", fr_bits[fb+1]);
      end
      lat = rsp_cyc[rb] - acc_cyc[ab] - 1;
      n_checks++;
      if (rsp_errl[rb] !== 1'b1 || lat != 437) begin
         n_fail++;
         $display("FAIL timeout_rsp: err %b latency %0d, required 1 437", rsp_errl[rb], lat);
      end
      n_checks++;
      if (rsp_data[rb] !== 8'hA5 || rsp_rdata !== 8'hA5) begin
         n_fail++;
         $display("FAIL timeout_rdata: got %h, required a5", rsp_rdata);
      end
   endtask

   task automatic test_reset_mid();
      int rb, ab, fb;
      rb = n_rsp;
      mem_byte = 8'h77;
      do_req(1'b0, 16'h4321, 8'h00);
      repeat (59) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if ({csb, sck, sdo, req_ready, rsp_valid} !== 5'b10010) begin
         n_fail++;
         $display("FAIL midreset_pins: csb/sck/sdo/ready/valid %b, required 10010",
                  {csb, sck, sdo, req_ready, rsp_valid});
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (200) @(negedge clk);
      n_checks++;
      if (n_rsp != rb) begin
         n_fail++;
         $display("FAIL midreset_norsp: %0d responses, required 0", n_rsp - rb);
      end
      rb = n_rsp; ab = n_acc; fb = nfr;
      mem_byte = 8'h3C;
      do_req(1'b0, 16'h0001, 8'h00);
      wait_rsp(rb + 1, 400, "midreset_read");
      check_read(rb, ab, fb, 24'h030001, 8'h3C, "midreset_read");
   endtask

   task automatic test_back_to_back();
      int rb, ab, fb, rh, i, gap;
      rb = n_rsp; ab = n_acc; fb = nfr; rh = ready_hi;
      mem_byte = 8'h81;
      @(negedge clk);
      req_valid = 1'b1;
      req_wr    = 1'b0;
      req_addr  = 16'h00F0;
      i = 0;
      while (n_acc < ab + 2 && i < 600) begin
         @(negedge clk);
         i++;
      end
      req_valid = 1'b0;
      wait_rsp(rb + 2, 400, "b2b");
      gap = acc_cyc[ab+1] - rsp_cyc[rb];
      n_checks++;
      if (n_acc != ab + 2 || gap != 1) begin
         n_fail++;
         $display("FAIL b2b_accept: accepts %0d spacing %0d, required 2 1", n_acc - ab, gap);
      end
      n_checks++;
      if (ready_hi != rh) begin
         n_fail++;
         $display("FAIL b2b_ready: ready high %0d cycles in txn, required 0", ready_hi - rh);
      end
      check_read(rb, ab, fb, 24'h0300F0, 8'h81, "b2b_first");
      check_read(rb + 1, ab + 1, fb + 1, 24'h0300F0, 8'h81, "b2b_second");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t, required completion", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_read();
      test_write();
      test_write_timeout();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
